ring_out_arbiter: RTL
=====================

// Module: ring_out_arbiter
// PURPOSE
//  Packet-level round-robin arbiter sharing one downstream TwoRegFifo write port (ring output link)
//  between NUM_REQ upstream FIFOs (ring-through plus local inject ports) at a PtRing stop.
//  Holds a grant for a whole multi-flit packet until its tail flit, then rotates.
//  Adds zero latency: requester read and downstream write happen in the same cycle.
// PARAMETERS
//  NUM_REQ     3    number of requester FIFOs, 2..8, need not be a power of 2
//  WIDTH       8    flit width incl. tail flag; bit WIDTH-1 = tail (1 = last flit of packet)
//  MAX_PKT_LEN 16   max flits per packet before oErr is raised, 2..255
// PORTS
//  clk        in   1               clock, rising edge
//  rst        in   1               asynchronous, active-high reset
//  iNotEmpty  in   NUM_REQ         requester FIFO has a flit; iRdDat[i] valid (first-word-fall-through)
//  iRdDat     in   NUM_REQ x WIDTH head flit of each requester FIFO
//  oRdEn      out  NUM_REQ         pop strobe to requester FIFO, one-hot or zero
//  iFul       in   1               downstream FIFO full
//  oWrEn      out  1               push strobe to downstream FIFO
//  oWrDat     out  WIDTH           flit to downstream FIFO (= iRdDat[grant])
//  oGntId     out  $clog2(NUM_REQ) current/last granted requester
//  oLocked    out  1               mid-packet, grant held
//  oErr       out  1               sticky: packet exceeded MAX_PKT_LEN
// BEHAVIOUR
//  Reset values: state IDLE, rrPtr=0, oGntId=0, oLocked=0, oErr=0, flitCnt=0;
//   oRdEn/oWrEn=0 (combinational, forced 0 while rst is high).
//  Transfer condition: xfer = iNotEmpty[g] & ~iFul. In a transfer cycle oRdEn[g]=1, oWrEn=1,
//   oWrDat=iRdDat[g], all in the same cycle. No strobe is ever issued while iFul=1.
//  IDLE: g = first i with iNotEmpty[i], searched from rrPtr upward, wrapping NUM_REQ-1 -> 0.
//   No requests or iFul=1: no strobe, state/rrPtr unchanged; re-arbitrate next cycle.
//   xfer with tail=1: stay IDLE, rrPtr <= (g+1) mod NUM_REQ, oGntId <= g.
//   xfer with tail=0: -> LOCK, lockId <= g, oGntId <= g, flitCnt <= 1.
//  LOCK: g = lockId only; all other requesters are ignored even when they are the only ones with data.
//   ~iNotEmpty[lockId] or iFul: stall, hold all state.
//   xfer with tail=0: flitCnt++ (saturates at 255); flitCnt reaching MAX_PKT_LEN sets oErr.
//   xfer with tail=1: -> IDLE, rrPtr <= (lockId+1) mod NUM_REQ, flitCnt <= 0.
//  oLocked = (state==LOCK), registered.
//  oErr clears only on rst. Arbitration continues unchanged after oErr is set.
//  Simultaneous requests: the rrPtr rotation makes each active requester win at most once per
//   NUM_REQ packets.
//  Reset mid-packet returns to IDLE immediately. The truncated packet downstream is the system's
//   responsibility, not this block's.
//  rrPtr arithmetic is mod NUM_REQ by explicit compare-and-wrap, never by truncation.
// STRUCTURE
//  ring_arb_pkg: typedef enum logic {IDLE, LOCK} arb_state_e; localparam TAIL_BIT = WIDTH-1;
//   function is_tail(flit).
//  Sub-module rr_pick #(N): combinational rotating priority encoder.
//   Inputs: req[N], ptr. Outputs: gnt_id, gnt_vld.
//  Top: state/rrPtr/lockId/flitCnt/oErr flops, mux for oWrDat, oRdEn decode.
// TESTING
//  1 Reset: rst=1 with all iNotEmpty=1 -> oRdEn=0, oWrEn=0, oGntId=0, oLocked=0, oErr=0.
//  2 Single-flit RR: NUM_REQ=3, all ports hold tail=1 flits, iFul=0
//    -> grants 0,1,2,0,1,2 on consecutive cycles, one flit per cycle.
//  3 Packet lock: port1 sends 3-flit packet (tail on 3rd) while port0/2 request
//    -> oWrEn 3 cycles all from port1, oLocked=1 for 2 cycles, next grant = port2.
//  4 Backpressure: iFul=1 for 4 cycles mid-packet -> no strobes, oGntId/oLocked held,
//    resumes with same lockId on iFul=0.
//  5 Starved lock: port0 locked, iNotEmpty[0]=0 for 3 cycles while port1 requests
//    -> port1 never granted until port0 tail.
//  6 Overlength/reset: MAX_PKT_LEN=4, 6-flit packet -> oErr=1 after 4th flit, sticky.
//    rst mid-packet -> IDLE, oLocked=0, oErr=0.

Source files
------------

// File: rtl/ring_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ring_arb_pkg
// Brief    : Shared types, constants and helpers for the ring output arbiter.
// Revision : 1.0
// ============================================================================
package ring_arb_pkg;

    localparam int FLIT_W_DEFAULT = 8;
    localparam int TAIL_BIT       = FLIT_W_DEFAULT - 1;
    localparam int FLIT_W_MAX     = 64;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    typedef enum logic {
        IDLE = ST_IDLE,
        LOCK = ST_LOCK
    } arb_state_e;

    // Tail flag lives in the MSB of a flit of the given width.
    function automatic logic is_tail(input logic [FLIT_W_MAX-1:0] flit, input int width);
        return |(flit & ({{(FLIT_W_MAX-1){1'b0}}, 1'b1} << (width - 1)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ring_out_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational rotating priority encoder; lowest distance from
//            ptr (wrapping at N) among asserted requests wins.
// Revision : 1.0
// ============================================================================
module rr_pick #(
    parameter int N = 3
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 gnt_vld
);

    localparam int ID_W = $clog2(N);

    int w_dist;
    int w_best;

    always_comb begin
        gnt_id  = '0;
        gnt_vld = 1'b0;
        w_dist  = 0;
        w_best  = 0;
        for (int i = 0; i < N; i++) begin
            w_dist = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + N - int'(ptr));
            if (req[i] && (!gnt_vld || (w_dist < w_best))) begin
                gnt_id  = ID_W'(i);
                gnt_vld = 1'b1;
                w_best  = w_dist;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ring_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ring_out_arbiter
// Brief    : Packet-level round-robin arbiter feeding one downstream FIFO
//            write port from NUM_REQ first-word-fall-through FIFOs.
// Revision : 1.0
// ============================================================================
module ring_out_arbiter
    import ring_arb_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int WIDTH       = 8,
    parameter int MAX_PKT_LEN = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         iNotEmpty,
    input  logic [WIDTH-1:0]           iRdDat [NUM_REQ],
    output logic [NUM_REQ-1:0]         oRdEn,
    input  logic                       iFul,
    output logic                       oWrEn,
    output logic [WIDTH-1:0]           oWrDat,
    output logic [$clog2(NUM_REQ)-1:0] oGntId,
    output logic                       oLocked,
    output logic                       oErr
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [0:0]      r_state;
    logic [ID_W-1:0] r_rr_ptr;
    logic [ID_W-1:0] r_lock_id;
    logic [ID_W-1:0] r_gnt_id;
    logic [7:0]      r_flit_cnt;
    logic            r_err;

    logic [ID_W-1:0] w_pick_id;
    logic            w_pick_vld;
    logic [ID_W-1:0] w_gid;
    logic [ID_W-1:0] w_gid_inc;
    logic            w_req_vld;
    logic            w_xfer;
    logic            w_tail;
    logic [7:0]      w_cnt_inc;
    logic [WIDTH-1:0] w_wr_dat;

    rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .req     (iNotEmpty),
        .ptr     (r_rr_ptr),
        .gnt_id  (w_pick_id),
        .gnt_vld (w_pick_vld)
    );

    // While locked only the owning requester is eligible, regardless of others.
    assign w_gid     = (r_state == ST_LOCK) ? r_lock_id : w_pick_id;
    assign w_req_vld = (r_state == ST_LOCK) ? iNotEmpty[r_lock_id] : w_pick_vld;
    assign w_xfer    = w_req_vld & ~iFul & ~rst;
    assign w_wr_dat  = iRdDat[w_gid];
    assign w_tail    = is_tail(FLIT_W_MAX'(w_wr_dat), WIDTH);
    assign w_gid_inc = (w_gid == ID_W'(NUM_REQ - 1)) ? '0 : (w_gid + 1'b1);
    assign w_cnt_inc = (r_flit_cnt == 8'hFF) ? 8'hFF : (r_flit_cnt + 8'd1);

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_rden
            assign oRdEn[i] = w_xfer & (w_gid == ID_W'(i));
        end
    endgenerate

    assign oWrEn   = w_xfer;
    assign oWrDat  = w_wr_dat;
    assign oGntId  = r_gnt_id;
    assign oLocked = (r_state == ST_LOCK);
    assign oErr    = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_lock_id  <= '0;
            r_gnt_id   <= '0;
            r_flit_cnt <= 8'd0;
            r_err      <= 1'b0;
        end else if (w_xfer) begin
            r_gnt_id <= w_gid;
            if (r_state == ST_IDLE) begin
                if (w_tail) begin
                    r_rr_ptr <= w_gid_inc;
                end else begin
                    r_state    <= ST_LOCK;
                    r_lock_id  <= w_gid;
                    r_flit_cnt <= 8'd1;
                end
            end else if (w_tail) begin
                r_state    <= ST_IDLE;
                r_rr_ptr   <= w_gid_inc;
                r_flit_cnt <= 8'd0;
            end else begin
                r_flit_cnt <= w_cnt_inc;
                if (w_cnt_inc >= 8'(MAX_PKT_LEN)) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
